// File: rtl/sram22_ctrl_pkg.sv
// rtl/sram22_ctrl_pkg.sv - shared types and constants for the SRAM22 port controller
package sram22_ctrl_pkg;

  typedef enum logic {INIT, RUN} state_e;

  localparam int DEF_DATA_WIDTH  = 32;
  localparam int DEF_ADDR_WIDTH  = 9;
  localparam int DEF_WMASK_WIDTH = 1;
  localparam int DEF_RSP_DEPTH   = 3;

  function automatic int rsp_cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/sram22_rsp_fifo.sv
// rtl/sram22_rsp_fifo.sv - response FIFO holding captured SRAM read data
module sram22_rsp_fifo
  import sram22_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int RSP_DEPTH  = DEF_RSP_DEPTH
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  push,
  input  logic [DATA_WIDTH-1:0]                 push_data,
  input  logic                                  pop,
  output logic [DATA_WIDTH-1:0]                 pop_data,
  output logic [rsp_cnt_width(RSP_DEPTH)-1:0]   count
);

  localparam int PW = $clog2(RSP_DEPTH);
  localparam logic [PW-1:0] LAST = PW'(RSP_DEPTH - 1);

  logic [DATA_WIDTH-1:0] mem [RSP_DEPTH];
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;

  // Pointers wrap explicitly so non-power-of-two depths work.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + 1'b1;
      if (pop)  rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  assign pop_data = (count != '0) ? mem[rd_ptr] : '0;

endmodule

// File: rtl/sram22_port_ctrl.sv
// rtl/sram22_port_ctrl.sv - valid/ready front end for single-port SRAM22 macros with zero-fill
module sram22_port_ctrl
  import sram22_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH    = DEF_ADDR_WIDTH,
  parameter int WMASK_WIDTH   = DEF_WMASK_WIDTH,
  parameter int RSP_DEPTH     = DEF_RSP_DEPTH,
  parameter bit INIT_ON_RESET = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst,
  output logic                   init_done,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic                   req_we,
  input  logic [WMASK_WIDTH-1:0] req_wmask,
  input  logic [ADDR_WIDTH-1:0]  req_addr,
  input  logic [DATA_WIDTH-1:0]  req_wdata,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [DATA_WIDTH-1:0]  rsp_rdata,
  output logic                   sram_we,
  output logic [WMASK_WIDTH-1:0] sram_wmask,
  output logic [ADDR_WIDTH-1:0]  sram_addr,
  output logic [DATA_WIDTH-1:0]  sram_din,
  input  logic [DATA_WIDTH-1:0]  sram_dout
);

  localparam int CW = rsp_cnt_width(RSP_DEPTH);
  localparam logic [CW:0] DEPTH_LIM = (CW + 1)'(RSP_DEPTH);

  state_e          state;
  state_e          state_nxt;
  logic [ADDR_WIDTH-1:0] cnt;
  logic            rd_pending;
  logic [CW-1:0]   fifo_count;
  logic            accept;
  logic [CW:0]     occupancy;

  // A pending read already owns a FIFO slot, so it counts against the credit.
  assign occupancy = {1'b0, fifo_count} + {{CW{1'b0}}, rd_pending};
  assign init_done = (state == RUN);
  assign req_ready = (state == RUN) && (occupancy < DEPTH_LIM);
  assign accept    = req_valid && req_ready;
  assign rsp_valid = (fifo_count != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= INIT_ON_RESET ? INIT : RUN;
      cnt        <= '0;
      rd_pending <= 1'b0;
    end else begin
      state      <= state_nxt;
      if (state == INIT) cnt <= cnt + 1'b1;
      rd_pending <= accept && !req_we;
    end
  end

  always_comb begin
    state_nxt  = state;
    sram_we    = 1'b0;
    sram_wmask = '0;
    sram_addr  = '0;
    sram_din   = '0;
    case (state)
      INIT: begin
        sram_we    = 1'b1;
        sram_wmask = '1;
        sram_addr  = cnt;
        if (cnt == '1) state_nxt = RUN;
      end
      RUN: begin
        if (accept) begin
          sram_we    = req_we;
          sram_wmask = req_wmask;
          sram_addr  = req_addr;
          sram_din   = req_wdata;
        end
      end
    endcase
  end

  sram22_rsp_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .RSP_DEPTH  (RSP_DEPTH)
  ) u_rsp_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (rd_pending),
    .push_data (sram_dout),
    .pop       (rsp_valid && rsp_ready),
    .pop_data  (rsp_rdata),
    .count     (fifo_count)
  );

endmodule

// File: tb/tb_sram22_port_ctrl.sv
// tb/tb_sram22_port_ctrl.sv - directed bench for sram22_port_ctrl with a behavioural macro
module tb_sram22_port_ctrl;

  localparam int DW    = 32;
  localparam int AW    = 9;
  localparam int WM    = 1;
  localparam int RD    = 3;
  localparam int DEPTH = 1 << AW;
  localparam int LW    = DW / WM;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          init_done;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_we = 1'b0;
  logic [WM-1:0] req_wmask = '0;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_wdata = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic [DW-1:0] rsp_rdata;
  logic          sram_we;
  logic [WM-1:0] sram_wmask;
  logic [AW-1:0] sram_addr;
  logic [DW-1:0] sram_din;
  logic [DW-1:0] sram_dout;

  always #5 clk = ~clk;

  sram22_port_ctrl #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .WMASK_WIDTH(WM), .RSP_DEPTH(RD), .INIT_ON_RESET(1'b1)
  ) dut (
    .clk(clk), .rst(rst), .init_done(init_done),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_wmask(req_wmask),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .sram_we(sram_we), .sram_wmask(sram_wmask), .sram_addr(sram_addr),
    .sram_din(sram_din), .sram_dout(sram_dout)
  );

  // Macro model: random power-up contents, garbage dout after a write.
  logic [DW-1:0] mem [DEPTH];
  logic          filled = 1'b0;
  always @(posedge clk) begin
    if (!filled) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= $urandom;
      filled <= 1'b1;
    end else if (sram_we) begin
      for (int b = 0; b < WM; b++)
        if (sram_wmask[b]) mem[sram_addr][b*LW +: LW] <= sram_din[b*LW +: LW];
      sram_dout <= $urandom;
    end else begin
      sram_dout <= mem[sram_addr];
    end
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_and_init(input string tag);
    int cycles;
    int early;
    rst = 1'b1; req_valid = 1'b0; rsp_ready = 1'b0;
    req_we = 1'b0; req_wmask = '0; req_addr = '0; req_wdata = '0;
    step();
    check({tag, "_rst_init_done"}, init_done, 0);
    check({tag, "_rst_req_ready"}, req_ready, 0);
    check({tag, "_rst_rsp_valid"}, rsp_valid, 0);
    check({tag, "_rst_rsp_rdata"}, rsp_rdata, 0);
    check({tag, "_rst_sram_we"},   sram_we, 1);
    check({tag, "_rst_sram_addr"}, sram_addr, 0);
    rst = 1'b0;
    req_valid = 1'b1; req_addr = 9'h055;
    cycles = 0; early = 0;
    while (!init_done && cycles < 1000) begin
      if (req_ready) early++;
      step();
      cycles++;
    end
    req_valid = 1'b0;
    check({tag, "_ready_during_init"}, early, 0);
    check({tag, "_init_cycles"}, cycles, DEPTH);
  endtask

  task automatic send(input logic we, input logic [WM-1:0] m, input logic [AW-1:0] a,
                      input logic [DW-1:0] d);
    int n;
    req_valid = 1'b1; req_we = we; req_wmask = m; req_addr = a; req_wdata = d;
    n = 0;
    while (n < 50) begin
      @(negedge clk);
      if (req_ready) break;
      @(posedge clk);
      n++;
    end
    check("send_accepted", n < 50, 1);
    step();
    req_valid = 1'b0;
  endtask

  task automatic recv(output logic [DW-1:0] data);
    int n;
    rsp_ready = 1'b1;
    n = 0;
    data = '0;
    while (n < 50) begin
      @(negedge clk);
      if (rsp_valid) begin
        data = rsp_rdata;
        break;
      end
      @(posedge clk);
      n++;
    end
    check("recv_arrived", n < 50, 1);
    step();
    rsp_ready = 1'b0;
  endtask

  typedef struct {
    logic          valid;
    logic          we;
    logic [WM-1:0] wmask;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          rready;
    logic          exp_ready;
    logic          exp_rvalid;
    logic [DW-1:0] exp_rdata;
  } vec_t;

  function automatic vec_t mk(input logic v, input logic we, input logic [WM-1:0] m,
                              input logic [AW-1:0] a, input logic [DW-1:0] d, input logic rr,
                              input logic er, input logic ev, input logic [DW-1:0] ed);
    vec_t t;
    t.valid = v; t.we = we; t.wmask = m; t.addr = a; t.wdata = d;
    t.rready = rr; t.exp_ready = er; t.exp_rvalid = ev; t.exp_rdata = ed;
    return t;
  endfunction

  vec_t          vecs [9];
  logic [DW-1:0] rd;
  logic [DW-1:0] exp_q [$];
  int            acc;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Write/read back-to-back, masked write, mixed traffic; rsp_ready held high.
    vecs[0] = mk(1'b1, 1'b1, 1'b1, 9'h1A5, 32'hDEADBEEF, 1'b1, 1'b1, 1'b0, 32'h0);
    vecs[1] = mk(1'b1, 1'b0, 1'b0, 9'h1A5, 32'h0,        1'b1, 1'b1, 1'b0, 32'h0);
    vecs[2] = mk(1'b1, 1'b1, 1'b1, 9'h010, 32'hCAFEF00D, 1'b1, 1'b1, 1'b0, 32'h0);
    vecs[3] = mk(1'b1, 1'b1, 1'b0, 9'h010, 32'h12345678, 1'b1, 1'b1, 1'b1, 32'hDEADBEEF);
    vecs[4] = mk(1'b1, 1'b0, 1'b0, 9'h010, 32'h0,        1'b1, 1'b1, 1'b0, 32'h0);
    vecs[5] = mk(1'b1, 1'b0, 1'b0, 9'h0FF, 32'h0,        1'b1, 1'b1, 1'b0, 32'h0);
    vecs[6] = mk(1'b0, 1'b0, 1'b0, 9'h000, 32'h0,        1'b1, 1'b1, 1'b1, 32'hCAFEF00D);
    vecs[7] = mk(1'b0, 1'b0, 1'b0, 9'h000, 32'h0,        1'b1, 1'b1, 1'b1, 32'h0);
    vecs[8] = mk(1'b0, 1'b0, 1'b0, 9'h000, 32'h0,        1'b1, 1'b1, 1'b0, 32'h0);

    reset_and_init("por");

    send(1'b0, '0, 9'h000, '0); recv(rd); check("zero_fill_0",   rd, 0);
    send(1'b0, '0, 9'h0FF, '0); recv(rd); check("zero_fill_255", rd, 0);
    send(1'b0, '0, 9'h1FF, '0); recv(rd); check("zero_fill_511", rd, 0);

    for (int i = 0; i < 9; i++) begin
      req_valid = vecs[i].valid; req_we = vecs[i].we; req_wmask = vecs[i].wmask;
      req_addr = vecs[i].addr; req_wdata = vecs[i].wdata; rsp_ready = vecs[i].rready;
      @(negedge clk);
      check($sformatf("vec%0d_req_ready", i), req_ready, vecs[i].exp_ready);
      check($sformatf("vec%0d_rsp_valid", i), rsp_valid, vecs[i].exp_rvalid);
      if (vecs[i].exp_rvalid)
        check($sformatf("vec%0d_rsp_rdata", i), rsp_rdata, vecs[i].exp_rdata);
      step();
    end
    req_valid = 1'b0;

    // Streaming: fill 0x100..0x13F, then 64 back-to-back reads.
    rsp_ready = 1'b1;
    for (int i = 0; i < 64; i++) begin
      req_valid = 1'b1; req_we = 1'b1; req_wmask = '1;
      req_addr = 9'(256 + i); req_wdata = 32'hA500_0000 | 32'(i);
      @(negedge clk);
      check($sformatf("wr_stream%0d_ready", i), req_ready, 1);
      step();
    end
    for (int c = 0; c < 66; c++) begin
      req_valid = (c < 64); req_we = 1'b0; req_addr = 9'(256 + (c % 64));
      @(negedge clk);
      if (c < 64) check($sformatf("rd_stream%0d_ready", c), req_ready, 1);
      if (c >= 2) begin
        check($sformatf("rd_stream%0d_valid", c - 2), rsp_valid, 1);
        check($sformatf("rd_stream%0d_data", c - 2), rsp_rdata, 32'hA500_0000 | 32'(c - 2));
      end
      step();
    end
    req_valid = 1'b0;
    check("stream_drained", rsp_valid, 0);

    // Backpressure: only RSP_DEPTH reads accepted while stalled.
    rsp_ready = 1'b0; acc = 0;
    req_valid = 1'b1; req_we = 1'b0; req_addr = 9'h100;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (req_ready) acc++;
      if (c >= 4) check($sformatf("bp_hold%0d", c), rsp_rdata, 32'hA500_0000);
      step();
      req_addr = 9'(256 + acc);
    end
    check("bp_accepted", acc, RD);
    check("bp_ready_low", req_ready, 0);
    check("bp_rsp_valid", rsp_valid, 1);
    req_valid = 1'b0; rsp_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check($sformatf("bp_rsp%0d_valid", k), rsp_valid, 1);
      check($sformatf("bp_rsp%0d_data", k), rsp_rdata, 32'hA500_0000 | 32'(k));
      step();
    end
    rsp_ready = 1'b0;
    check("bp_empty", rsp_valid, 0);
    check("bp_ready_resumed", req_ready, 1);
    send(1'b0, '0, 9'h1A5, '0); recv(rd); check("bp_resume_read", rd, 32'hDEADBEEF);

    // Reset with two FIFO entries and one read pending.
    rsp_ready = 1'b0; req_we = 1'b0;
    for (int c = 0; c < 3; c++) begin
      req_valid = 1'b1; req_addr = 9'(256 + c);
      @(negedge clk);
      check($sformatf("mid_fill%0d_ready", c), req_ready, 1);
      step();
    end
    req_valid = 1'b0;
    check("mid_pre_rsp_valid", rsp_valid, 1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("mid_rst_rsp_valid", rsp_valid, 0);
    check("mid_rst_req_ready", req_ready, 0);
    check("mid_rst_init_done", init_done, 0);
    reset_and_init("mid");
    send(1'b0, '0, 9'h100, '0); recv(rd); check("mid_post_0x100", rd, 0);
    send(1'b0, '0, 9'h1A5, '0); recv(rd); check("mid_post_0x1A5", rd, 0);
    step();
    check("mid_no_extra_rsp", rsp_valid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
